mips_data_memory: RTL

//  Downstream data memory for the MIPS core's cache miss/write-back path. Accepts one word request
//  (byte address, 4 byte lanes, write enable) and completes it after a fixed, parameterised latency.

---
 rtl/mips_mem_pkg.sv | 22 ++
 rtl/mips_mem_bank.sv | 41 ++++
 rtl/mips_data_memory.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_pkg
//  Description : Shared types and constants for the MIPS downstream data
//                memory (FSM state encoding, byte-lane word type).
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Lane i carries byte address (word base + i)
    typedef logic [7:0] byte_lanes_t [0:WORD_BYTES-1];

endpackage
`default_nettype wire

// File: rtl/mips_mem_bank.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_bank
//  Description : One byte lane of the data memory. MEM_WORDS x 8 storage with
//                synchronous write and a registered, enable-gated read port.
//                The storage array itself is never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_bank #(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             re,
    input  logic             we,
    input  logic [IDX_W-1:0] index,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] r_mem [0:MEM_WORDS-1];

    // Storage write: plain synchronous array write, no reset
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[index] <= wdata;
        end
    end

    // Read register: loads only when a read completes, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 8'h00;
        end else if (re) begin
            rdata <= r_mem[index];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : mips_data_memory
//  Description : Slow word-wide data memory behind the MIPS cache. Accepts one
//                request in IDLE, waits LATENCY cycles, then commits the access
//                and pulses mem_ready for one cycle. Out-of-range addresses
//                raise mem_err with the pulse and are otherwise discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_data_memory
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_write_en,
    input  logic [31:0] mem_addr,
    input  byte_lanes_t mem_data_in,
    output byte_lanes_t mem_data_out,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_err
);

    localparam int          c_IDX_W    = $clog2(MEM_WORDS);
    localparam logic [3:0]  c_CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [31:0] c_WORDS    = 32'(MEM_WORDS);

    mem_state_t         r_state;
    logic [3:0]         r_cnt;
    logic               r_we;
    logic               r_oor;
    logic [c_IDX_W-1:0] r_idx;
    byte_lanes_t        r_wdata;
    logic               r_ready;
    logic               r_busy;
    logic               r_err;
    logic               r_zero;

    logic [31:0]        w_word;
    logic               w_req_oor;
    logic               w_enter_resp;
    logic               w_sel_we;
    logic               w_sel_oor;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic               w_bank_re;
    logic               w_bank_we;
    byte_lanes_t        w_rdata;

    // Word index of the incoming request; low two address bits drop out
    assign w_word    = mem_addr >> 2;
    assign w_req_oor = (w_word >= c_WORDS);

    // Cycle whose closing edge moves the FSM into RESP. With LATENCY==1 that is
    // the accepting edge itself, so the request fields come straight from the
    // ports rather than from the latched copies.
    assign w_enter_resp = ((r_state == IDLE) && mem_req && (LATENCY == 1)) ||
                          ((r_state == WAIT) && (r_cnt == 4'd1));
    assign w_sel_we  = (r_state == IDLE) ? mem_write_en           : r_we;
    assign w_sel_oor = (r_state == IDLE) ? w_req_oor              : r_oor;
    assign w_sel_idx = (r_state == IDLE) ? w_word[c_IDX_W-1:0]    : r_idx;

    // Reads land in the bank registers on entry to RESP so data shows with the
    // ready pulse; writes commit on the edge that leaves RESP.
    assign w_bank_re = w_enter_resp && !w_sel_we && !w_sel_oor;
    assign w_bank_we = (r_state == RESP) && r_we && !r_oor;

    // Request FSM with latency counter and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_oor   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '{default: 8'h00};
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mem_req) begin
                        r_we    <= mem_write_en;
                        r_oor   <= w_req_oor;
                        r_idx   <= w_word[c_IDX_W-1:0];
                        r_wdata <= mem_data_in;
                        r_cnt   <= c_CNT_LOAD;
                        r_busy  <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                            r_ready <= 1'b1;
                            r_err   <= w_req_oor;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                        r_err   <= r_oor;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output mask: an out-of-range read shows all-zero data until the next read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if (w_enter_resp && !w_sel_we) begin
            r_zero <= w_sel_oor;
        end
    end

    generate
        for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
            mips_mem_bank #(
                .MEM_WORDS (MEM_WORDS),
                .IDX_W     (c_IDX_W)
            ) u_bank (
                .clk   (clk),
                .rst   (rst),
                .re    (w_bank_re),
                .we    (w_bank_we),
                .index (w_sel_idx),
                .wdata (r_wdata[i]),
                .rdata (w_rdata[i])
            );
            assign mem_data_out[i] = r_zero ? 8'h00 : w_rdata[i];
        end
    endgenerate

    assign mem_ready = r_ready;
    assign mem_busy  = r_busy;
    assign mem_err   = r_err;

endmodule
`default_nettype wire
